// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared pong geometry, FSM encoding and collision helpers
package pong_pkg;

  localparam int CLK_HZ       = 25175000;
  localparam int H_ACTIVE     = 640;
  localparam int V_ACTIVE     = 480;
  localparam int SQ_SIZE      = 16;
  localparam int PDL_HEIGHT   = 96;
  localparam int LPDL_X       = 32;
  localparam int RPDL_X       = 608;
  localparam int SERVE_FRAMES = 60;
  localparam int CENTRE_X     = (H_ACTIVE - SQ_SIZE) / 2;
  localparam int CENTRE_Y     = (V_ACTIVE - SQ_SIZE) / 2;

  typedef enum logic [1:0] {
    SERVE = 2'd0,
    MOVE  = 2'd1,
    MISS  = 2'd2
  } state_t;

  function automatic logic overlaps(input logic [9:0] py, input logic [9:0] pdl);
    return (({1'b0, py} + 11'(SQ_SIZE)) > {1'b0, pdl}) &&
           ({1'b0, py} < ({1'b0, pdl} + 11'(PDL_HEIGHT)));
  endfunction

  // Distance between square centre and paddle centre, clamped to half a paddle.
  function automatic logic [6:0] hit_dist(input logic [9:0] py, input logic [9:0] pdl);
    logic [11:0] a;
    logic [11:0] b;
    logic [11:0] d;
    a = {2'b00, py} + 12'(SQ_SIZE / 2);
    b = {2'b00, pdl} + 12'(PDL_HEIGHT / 2);
    d = (a >= b) ? (a - b) : (b - a);
    return (d > 12'(PDL_HEIGHT / 2)) ? 7'(PDL_HEIGHT / 2) : d[6:0];
  endfunction

endpackage

// File: rtl/rate_stepper.sv
// rtl/rate_stepper.sv - velocity accumulator emitting one step per CLK_HZ of accumulated speed
module rate_stepper
  import pong_pkg::*;
#(
  parameter int CLK_HZ    = pong_pkg::CLK_HZ,
  parameter int VEL_WIDTH = 10
) (
  input  logic                 clk_0,
  input  logic                 rst,
  input  logic                 en,
  input  logic                 clr,
  input  logic [VEL_WIDTH-1:0] vel,
  output logic                 step
);

  localparam int AW = $clog2(CLK_HZ) + 1;
  localparam int SW = ((AW > VEL_WIDTH) ? AW : VEL_WIDTH) + 1;
  localparam logic [SW-1:0] LIMIT = SW'(CLK_HZ);

  logic [AW-1:0] acc_q;
  logic [AW-1:0] acc_d;
  logic [SW-1:0] sum;

  assign sum = SW'(acc_q) + SW'(vel);

  always_comb begin
    step  = 1'b0;
    acc_d = acc_q;
    if (en) begin
      if (sum >= LIMIT) begin
        step  = 1'b1;
        acc_d = AW'(sum - LIMIT);
      end else begin
        acc_d = AW'(sum);
      end
    end
  end

  always_ff @(posedge clk_0) begin
    if (rst || clr) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/square_motion.sv
// rtl/square_motion.sv - ball motion, wall bounce, paddle contact and miss detection
module square_motion
  import pong_pkg::*;
#(
  parameter int CLK_HZ    = pong_pkg::CLK_HZ,
  parameter int VEL_WIDTH = 10
) (
  input  logic                 clk_0,
  input  logic                 rst,
  input  logic                 frame_tick,
  input  logic [9:0]           lpdl_y,
  input  logic [9:0]           rpdl_y,
  input  logic [VEL_WIDTH-1:0] sq_xvel,
  input  logic [VEL_WIDTH-1:0] sq_yvel,
  input  logic                 game_over,
  input  logic                 game_startup,
  output logic [9:0]           sq_x,
  output logic [9:0]           sq_y,
  output logic                 paddle_hit,
  output logic [6:0]           hit_y,
  output logic                 sq_missed,
  output logic                 miss_left
);

  localparam int             CW      = $clog2(SERVE_FRAMES + 1);
  localparam logic [CW-1:0]  SERVE_N = CW'(SERVE_FRAMES);
  localparam logic [9:0]     CX      = 10'(CENTRE_X);
  localparam logic [9:0]     CY      = 10'(CENTRE_Y);
  localparam logic [9:0]     X_MAX   = 10'(H_ACTIVE - SQ_SIZE);
  localparam logic [9:0]     Y_MAX   = 10'(V_ACTIVE - SQ_SIZE);
  localparam logic [9:0]     X_LFACE = 10'(LPDL_X);
  localparam logic [9:0]     X_RFACE = 10'(RPDL_X - SQ_SIZE);

  state_t        state_q;
  logic [CW-1:0] serve_cnt_q;
  logic [9:0]    pos_x_q, pos_y_q, sq_x_q, sq_y_q;
  logic          x_right_q, y_down_q;
  logic          paddle_hit_q, sq_missed_q, miss_left_q;
  logic [6:0]    hit_y_q;

  logic freeze, in_move, x_step, y_step, acc_clr;
  logic l_face, r_face, l_edge, r_edge, y_wall, miss_now;

  assign freeze  = game_over | game_startup;
  assign in_move = (state_q == MOVE) && !freeze;

  // Collision terms all use the pre-step position of this cycle.
  assign l_face   = !x_right_q && (pos_x_q == X_LFACE) && overlaps(pos_y_q, lpdl_y);
  assign r_face   =  x_right_q && (pos_x_q == X_RFACE) && overlaps(pos_y_q, rpdl_y);
  assign l_edge   = !x_right_q && (pos_x_q == 10'd0);
  assign r_edge   =  x_right_q && (pos_x_q == X_MAX);
  assign y_wall   = y_down_q ? (pos_y_q == Y_MAX) : (pos_y_q == 10'd0);
  assign miss_now = x_step && !l_face && !r_face && (l_edge || r_edge);
  assign acc_clr  = freeze || miss_now;

  rate_stepper #(.CLK_HZ(CLK_HZ), .VEL_WIDTH(VEL_WIDTH)) u_x_stepper (
    .clk_0 (clk_0),
    .rst   (rst),
    .en    (in_move),
    .clr   (acc_clr),
    .vel   (sq_xvel),
    .step  (x_step)
  );

  rate_stepper #(.CLK_HZ(CLK_HZ), .VEL_WIDTH(VEL_WIDTH)) u_y_stepper (
    .clk_0 (clk_0),
    .rst   (rst),
    .en    (in_move),
    .clr   (acc_clr),
    .vel   (sq_yvel),
    .step  (y_step)
  );

  always_ff @(posedge clk_0) begin
    paddle_hit_q <= 1'b0;
    sq_missed_q  <= 1'b0;
    if (rst) begin
      state_q     <= SERVE;
      serve_cnt_q <= '0;
      pos_x_q     <= CX;
      pos_y_q     <= CY;
      sq_x_q      <= CX;
      sq_y_q      <= CY;
      x_right_q   <= 1'b1;
      y_down_q    <= 1'b1;
      hit_y_q     <= '0;
      miss_left_q <= 1'b0;
    end else if (freeze) begin
      state_q     <= SERVE;
      serve_cnt_q <= '0;
      pos_x_q     <= CX;
      pos_y_q     <= CY;
      sq_x_q      <= CX;
      sq_y_q      <= CY;
    end else begin
      if (frame_tick) begin
        sq_x_q <= pos_x_q;
        sq_y_q <= pos_y_q;
      end
      case (state_q)
        SERVE: begin
          if (serve_cnt_q == SERVE_N) begin
            state_q     <= MOVE;
            serve_cnt_q <= '0;
          end else if (frame_tick) begin
            serve_cnt_q <= serve_cnt_q + 1'b1;
          end
        end
        MOVE: begin
          if (y_step) begin
            if (y_wall)        y_down_q <= ~y_down_q;
            else if (y_down_q) pos_y_q  <= pos_y_q + 10'd1;
            else               pos_y_q  <= pos_y_q - 10'd1;
          end
          if (x_step) begin
            if (l_face || r_face) begin
              x_right_q    <= ~x_right_q;
              paddle_hit_q <= 1'b1;
              hit_y_q      <= hit_dist(pos_y_q, l_face ? lpdl_y : rpdl_y);
            end else if (l_edge || r_edge) begin
              // Miss overrides any same-cycle y step: reposition and serve toward the loser.
              state_q     <= MISS;
              sq_missed_q <= 1'b1;
              miss_left_q <= l_edge;
              x_right_q   <= r_edge;
              y_down_q    <= ~y_down_q;
              pos_x_q     <= CX;
              pos_y_q     <= CY;
            end else if (x_right_q) begin
              pos_x_q <= pos_x_q + 10'd1;
            end else begin
              pos_x_q <= pos_x_q - 10'd1;
            end
          end
        end
        MISS: begin
          state_q     <= SERVE;
          serve_cnt_q <= '0;
        end
        default: state_q <= SERVE;
      endcase
    end
  end

  assign sq_x       = sq_x_q;
  assign sq_y       = sq_y_q;
  assign paddle_hit = paddle_hit_q;
  assign hit_y      = hit_y_q;
  assign sq_missed  = sq_missed_q;
  assign miss_left  = miss_left_q;

endmodule

// File: tb/tb_square_motion.sv
// tb/tb_square_motion.sv - directed table-driven bench for square_motion
module tb_square_motion;

  logic       clk_0 = 1'b0;
  logic       rst = 1'b1;
  logic       frame_tick = 1'b0;
  logic       game_over = 1'b0;
  logic       game_startup = 1'b0;
  logic [9:0] lpdl_y = 10'd0;
  logic [9:0] rpdl_y = 10'd0;
  logic [9:0] sq_xvel = 10'd0;
  logic [9:0] sq_yvel = 10'd0;
  logic [9:0] sq_x, sq_y;
  logic       paddle_hit, sq_missed, miss_left;
  logic [6:0] hit_y;

  int checks = 0;
  int errors = 0;
  int hit_cnt = 0;
  int miss_cnt = 0;
  int h0, m0;

  typedef struct {
    int lpdl; int rpdl; int ny; int nx;
    int ex; int ey; int ehits; int ehy;
  } row_t;
  row_t rows[6];

  square_motion #(.CLK_HZ(1000), .VEL_WIDTH(10)) dut (
    .clk_0        (clk_0),
    .rst          (rst),
    .frame_tick   (frame_tick),
    .lpdl_y       (lpdl_y),
    .rpdl_y       (rpdl_y),
    .sq_xvel      (sq_xvel),
    .sq_yvel      (sq_yvel),
    .game_over    (game_over),
    .game_startup (game_startup),
    .sq_x         (sq_x),
    .sq_y         (sq_y),
    .paddle_hit   (paddle_hit),
    .hit_y        (hit_y),
    .sq_missed    (sq_missed),
    .miss_left    (miss_left)
  );

  always #5 clk_0 = ~clk_0;

  always @(posedge clk_0) begin
    if (paddle_hit) hit_cnt++;
    if (sq_missed) miss_cnt++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    frame_tick = 1'b1;
    @(negedge clk_0);
    frame_tick = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk_0);
  endtask

  task automatic serve();
    repeat (60) tick();
    idle(3);
  endtask

  task automatic move_x(input int n);
    sq_xvel = 10'd1000;
    sq_yvel = 10'd0;
    idle(n);
    sq_xvel = 10'd0;
  endtask

  task automatic move_y(input int n);
    sq_xvel = 10'd0;
    sq_yvel = 10'd1000;
    idle(n);
    sq_yvel = 10'd0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1);
  end

  initial begin
    // Rally from (312,1) heading right/down: bounce off each paddle, then slip past the left face.
    rows[0] = '{200,   0,   0, 281, 592,   1, 1, 39};
    rows[1] = '{200,   0, 239, 561,  32, 240, 1,  0};
    rows[2] = '{200, 200,  40, 561, 592, 280, 1, 40};
    rows[3] = '{200, 200,  15, 561,  32, 295, 1, 48};
    rows[4] = '{200, 250,   0, 561, 592, 295, 1,  5};
    rows[5] = '{  0, 250, 105, 592,   0, 400, 0,  5};

    idle(3);
    rst = 1'b0;
    chk("reset_sq_x", int'(sq_x), 312);
    chk("reset_sq_y", int'(sq_y), 232);
    chk("reset_paddle_hit", int'(paddle_hit), 0);
    chk("reset_sq_missed", int'(sq_missed), 0);
    chk("reset_hit_y", int'(hit_y), 0);
    chk("reset_miss_left", int'(miss_left), 0);

    sq_xvel = 10'd1000;
    repeat (59) tick();
    idle(10);
    tick();
    sq_xvel = 10'd0;
    chk("serve_hold_x", int'(sq_x), 312);
    idle(3);
    move_x(5);
    tick();
    chk("serve_start_x", int'(sq_x), 317);

    sq_xvel = 10'd300;
    idle(1000);
    sq_xvel = 10'd0;
    tick();
    chk("rate300_x", int'(sq_x), 617);
    chk("rate300_y", int'(sq_y), 232);

    move_x(7);
    tick();
    chk("right_edge_x", int'(sq_x), 624);
    sq_xvel = 10'd1000;
    @(negedge clk_0);
    sq_xvel = 10'd0;
    chk("rmiss_pulse", int'(sq_missed), 1);
    chk("rmiss_side", int'(miss_left), 0);
    @(negedge clk_0);
    chk("rmiss_pulse_end", int'(sq_missed), 0);
    tick();
    chk("rmiss_centre_x", int'(sq_x), 312);
    chk("rmiss_centre_y", int'(sq_y), 232);
    serve();

    move_y(232);
    tick();
    chk("wall_reach_y", int'(sq_y), 0);
    move_y(1);
    tick();
    chk("wall_flip_y", int'(sq_y), 0);
    move_y(1);
    tick();
    chk("wall_leave_y", int'(sq_y), 1);

    for (int i = 0; i < 6; i++) begin
      lpdl_y = 10'(rows[i].lpdl);
      rpdl_y = 10'(rows[i].rpdl);
      h0 = hit_cnt;
      m0 = miss_cnt;
      move_y(rows[i].ny);
      move_x(rows[i].nx);
      tick();
      chk($sformatf("row%0d_x", i), int'(sq_x), rows[i].ex);
      chk($sformatf("row%0d_y", i), int'(sq_y), rows[i].ey);
      chk($sformatf("row%0d_hits", i), hit_cnt - h0, rows[i].ehits);
      chk($sformatf("row%0d_hit_y", i), int'(hit_y), rows[i].ehy);
      chk($sformatf("row%0d_misses", i), miss_cnt - m0, 0);
    end

    sq_xvel = 10'd1000;
    @(negedge clk_0);
    sq_xvel = 10'd0;
    chk("lmiss_pulse", int'(sq_missed), 1);
    chk("lmiss_side", int'(miss_left), 1);
    @(negedge clk_0);
    chk("lmiss_pulse_end", int'(sq_missed), 0);
    tick();
    chk("lmiss_centre_x", int'(sq_x), 312);
    chk("lmiss_centre_y", int'(sq_y), 232);
    serve();
    move_x(1);
    move_y(1);
    tick();
    chk("lserve_dir_x", int'(sq_x), 311);
    chk("lserve_dir_y", int'(sq_y), 231);

    move_x(5);
    m0 = miss_cnt;
    game_startup = 1'b1;
    sq_xvel = 10'd1000;
    @(negedge clk_0);
    chk("freeze_now_x", int'(sq_x), 312);
    chk("freeze_now_y", int'(sq_y), 232);
    repeat (70) tick();
    game_startup = 1'b0;
    idle(10);
    tick();
    sq_xvel = 10'd0;
    chk("freeze_count_x", int'(sq_x), 312);
    chk("freeze_no_miss", miss_cnt - m0, 0);
    serve();
    move_x(3);
    tick();
    chk("freeze_resume_x", int'(sq_x), 309);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
